alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 31 +++
 rtl/alu.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: ALU command codes, MIPS opcode/funct constants and FSM state encodings
package alu_issue_ctrl_pkg;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;
endpackage

// File: rtl/alu.sv
// alu: 3-bit-command ALU whose result is registered one clock after the command is presented
module alu
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0] r;
  always_comb begin
    case (cmd)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_AND:  r = a & b;
      ALU_NAND: r = ~(a & b);
      ALU_NOR:  r = ~(a | b);
      default:  r = a | b;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) result <= '0;
    else if (en) result <= r;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes a MIPS ALU instruction, drives the registered ALU and returns a flagged result
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_rs_val,
  input  logic [WIDTH-1:0] in_rt_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_dest,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal
);
  logic [1:0]       state_q, state_d;
  logic             ready_q, ovf_chk_q, zero_q, ovf_q, ill_q, accept, ovf;
  logic [2:0]       cmd_q, dec_cmd;
  logic [WIDTH-1:0] a_q, b_q, res_q, alu_res, dec_b, sext, zext;
  logic [4:0]       dest_q, dec_dest;
  logic             dec_legal, dec_ovf;
  logic [5:0]       opcode, funct;
  logic             unused;
  assign unused = ^{in_instr[25:21], in_instr[10:6]};
  assign opcode = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign sext   = {{(WIDTH-16){in_instr[15]}}, in_instr[15:0]};
  assign zext   = {{(WIDTH-16){1'b0}}, in_instr[15:0]};
  assign accept = in_valid & ready_q;
  always_comb begin
    dec_cmd   = ALU_ADD;
    dec_b     = in_rt_val;
    dec_dest  = in_instr[15:11];
    dec_legal = 1'b1;
    dec_ovf   = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU: dec_ovf = ~funct[0];
        FN_SUB, FN_SUBU: begin dec_cmd = ALU_SUB; dec_ovf = ~funct[0]; end
        FN_AND:          dec_cmd = ALU_AND;
        FN_OR:           dec_cmd = ALU_OR;
        FN_XOR:          dec_cmd = ALU_XOR;
        FN_NOR:          dec_cmd = ALU_NOR;
        FN_SLT:          dec_cmd = ALU_SLT;
        default:         dec_legal = 1'b0;
      endcase
    end else begin
      dec_dest = in_instr[20:16];
      dec_b    = sext;
      case (opcode)
        OP_ADDI, OP_ADDIU: dec_ovf = ~opcode[0];
        OP_SLTI:           dec_cmd = ALU_SLT;
        OP_ANDI:           begin dec_cmd = ALU_AND; dec_b = zext; end
        OP_ORI:            begin dec_cmd = ALU_OR;  dec_b = zext; end
        OP_XORI:           begin dec_cmd = ALU_XOR; dec_b = zext; end
        default:           dec_legal = 1'b0;
      endcase
    end
  end
  assign ovf = ovf_chk_q & (alu_res[WIDTH-1] != a_q[WIDTH-1]) &
               ((cmd_q == ALU_SUB) ^ (a_q[WIDTH-1] == b_q[WIDTH-1]));
  assign state_d = (state_q == ST_IDLE)    ? (accept ? (dec_legal ? ST_ISSUE : ST_RESP) : ST_IDLE) :
                   (state_q == ST_ISSUE)   ? ST_CAPTURE :
                   (state_q == ST_CAPTURE) ? ST_RESP :
                   (out_ready ? ST_IDLE : ST_RESP);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      cmd_q     <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      ovf_chk_q <= 1'b0;
      dest_q    <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d == ST_IDLE;
      if (accept) begin
        cmd_q     <= dec_cmd;
        a_q       <= in_rs_val;
        b_q       <= dec_b;
        ovf_chk_q <= dec_ovf;
        dest_q    <= dec_dest;
        ill_q     <= ~dec_legal;
        if (!dec_legal) begin
          res_q  <= '0;
          zero_q <= 1'b1;
          ovf_q  <= 1'b0;
        end
      end
      if (state_q == ST_CAPTURE) begin
        res_q  <= alu_res;
        zero_q <= ~|alu_res;
        ovf_q  <= ovf;
      end
    end
  end
  alu #(.WIDTH(WIDTH)) u_alu (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == ST_ISSUE),
    .cmd    (cmd_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res)
  );
  assign in_ready    = ready_q;
  assign out_valid   = state_q == ST_RESP;
  assign out_result  = res_q;
  assign out_dest    = dest_q;
  assign out_zero    = zero_q;
  assign out_ovf     = ovf_q;
  assign out_illegal = ill_q;
endmodule
